// File: rtl/seq_shift_add_mul_if.sv
// seq_shift_add_mul_if: operand/result handshake bundle for the shift-and-add multiplier.
interface seq_shift_add_mul_if #(parameter int WIDTH = 8);
   localparam int CW = $clog2(WIDTH) + 1;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   o;
   logic [CW-1:0]        cycles;
   logic                 busy;
   modport master (output in_valid, a, b, signed_mode, out_ready,
                   input  in_ready, out_valid, o, cycles, busy);
   modport slave  (input  in_valid, a, b, signed_mode, out_ready,
                   output in_ready, out_valid, o, cycles, busy);
endinterface

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: iterative sign-magnitude shift-and-add multiplier with optional constant-time latency.
module seq_shift_add_mul #(
   parameter int WIDTH     = 8,
   parameter int CT_TIME   = 0,
   parameter int SIGNED_EN = 1
) (
   input logic                clk,
   input logic                rst_n,
   seq_shift_add_mul_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t               state_q;
   logic [WIDTH-1:0]     a_q, b_q, a_d, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, o_q, o_d;
   logic [CW-1:0]        cnt_q, cyc_q;
   logic                 neg_q, neg_d, sgn, term;
   always_comb begin
      sgn   = (SIGNED_EN != 0) && bus.signed_mode;
      a_d   = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_d   = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      neg_d = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      term  = (CT_TIME != 0) ? (cnt_q == CW'(WIDTH)) : ((a_q == '0) || (b_q == '0));
      acc_d = acc_q + (b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
      o_d   = neg_q ? -acc_q : acc_q;
   end
   // Handshake outputs decode straight from the state register.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.o         = o_q;
   assign bus.cycles    = cyc_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         o_q     <= '0;
         cyc_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               a_q     <= a_d;
               b_q     <= b_d;
               neg_q   <= neg_d;
               acc_q   <= '0;
               cnt_q   <= '0;
               state_q <= CALC;
            end
            CALC: if (term) begin
               o_q     <= o_d;
               cyc_q   <= cnt_q;
               state_q <= DONE;
            end else begin
               acc_q <= acc_d;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + CW'(1);
            end
            DONE: if (bus.out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/seq_shift_add_mul.md
# seq_shift_add_mul

Parametrised sequential shift-and-add multiplier with a valid/ready handshake on both sides, selectable signed/unsigned operation, and a compile-time constant-time mode. It is the general-width successor of the team's fixed 8-bit multiplier. It serves as the arithmetic datapath under test in the two-copy timing-leakage harnesses, and as a standalone iterative multiplier elsewhere. It exports its iteration count so that harnesses can compare latency directly.

## Interface
- WIDTH, 8: operand width in bits; must be at least 2. The result is 2*WIDTH bits.
- CT_TIME, 0: 1 makes latency data-independent (always WIDTH iterations); 0 enables early termination.
- SIGNED_EN, 1: 1 honours `signed_mode`; 0 forces unsigned operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  operands are two's complement; sampled at accept.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- o  out  2*WIDTH  product.
- cycles  out  $clog2(WIDTH)+1  number of add/shift iterations performed; valid with out_valid.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Encoding is free.
- **Reset:**
  - State goes to IDLE.
  - Every register clears: a_reg, b_reg, acc, counter, neg, o, cycles.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, o=0, cycles=0.
  - Reset asserted mid-operation aborts it immediately; nothing is output.
- **IDLE:** accept when in_valid && in_ready, then go to CALC.
  - If SIGNED_EN && signed_mode: a_reg=|a|, b_reg=|b|, neg=a[W-1]^b[W-1].
  - Otherwise: a_reg=a, b_reg=b, neg=0.
  - Magnitudes are taken as unsigned WIDTH-bit values, so |-2^(W-1)| = 2^(W-1) is representable.
  - acc=0, counter=0.
- **CALC:** evaluate `term` each cycle.
  - CT_TIME=0: term = (a_reg==0) || (b_reg==0).
  - CT_TIME=1: term = (counter==WIDTH).
  - If term: o <= neg ? -acc : acc (2*WIDTH-bit two's complement), cycles <= counter, go to DONE. No add on this cycle.
  - Else: if b_reg[0], acc <= acc + (a_reg << counter), computed at 2*WIDTH bits. Then b_reg <= b_reg >> 1 (logical) and counter <= counter+1.
  - In CT_TIME=1, b_reg==0 iterations still occur and add zero.
- **DONE:** o and cycles are held stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE.
  - A result and a new operand are never exchanged in the same cycle.
- in_valid is ignored outside IDLE.
- o retains its value in IDLE until the next result is written.
- Overflow is impossible: |product| <= 2^(2W-2) for signed operation and < 2^(2W) for unsigned.

## Timing
- Let accept occur at edge E0, and let k = iterations performed.
  - out_valid rises after edge E(k+1).
  - in_ready rises the cycle after the output handshake edge.
- CT_TIME=0: k = (a_reg==0) ? 0 : (index of the highest set bit of b_reg)+1.
  - k=0 gives out_valid one cycle after accept.
- CT_TIME=1: k = WIDTH for all operands, so latency is WIDTH+1 cycles after accept.
- Throughput: at most one operation per k+3 cycles, with out_ready held high.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.

## Test plan
- **Unsigned early termination:** WIDTH=8, CT_TIME=0, unsigned, a=13, b=11 -> o=143, cycles=4, out_valid 5 cycles after accept.
- **Zero operands:**
  - b=0, a=200, CT_TIME=0 -> o=0, cycles=0, out_valid 1 cycle after accept.
  - a=0, b=0xFF, CT_TIME=0 -> o=0, cycles=0.
  - Same operands with CT_TIME=1 -> cycles=8, latency 9 cycles.
- **Signed operation:**
  - a=0xFD (-3), b=7 -> o=0xFFEB (-21), cycles=3.
  - a=b=0x80 (-128) -> o=0x4000, cycles=8.
  - signed_mode=0 with a=b=0x80 -> o=0x4000.
  - SIGNED_EN=0 with a=0xFD, b=7, signed_mode=1 -> o=1771.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles after out_valid -> o, cycles and out_valid stay stable, in_ready=0, and in_valid pulses are ignored.
  - Raise out_ready -> in_ready is high the next cycle, and a back-to-back operand is accepted.
- **Reset mid-operation:** assert rst_n=0 during cycle 2 of CALC -> out_valid=0, o=0, in_ready=1 immediately. A later a=5, b=6 produces o=30 normally.
